// File: rtl/axis_stream_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_stream_fifo : elastic AXI4-Stream buffer with optional store-and-forward
// Revision 1.0
// ---------------------------------------------------------------------------
module axis_stream_fifo #(
   parameter int DW       = 8,
   parameter int DEPTH    = 8,
   parameter int PKT_MODE = 0
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [DW-1:0]              s_tdata,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic                       s_tlast,
   output logic [DW-1:0]              m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic                       m_tlast,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic [$clog2(DEPTH):0]     pkt_count,
   output logic                       oversize
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_HOLD  = 1'b0,
      ST_FORCE = 1'b1
   } rel_state_t;

   logic [DW:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   fill_q, fill_d;
   logic [AW:0]   pkt_q, pkt_d;
   rel_state_t    state_q, state_d;
   logic          oversize_q, oversize_d;
   logic          run_q, run_d;

   logic          full;
   logic          empty;
   logic          out_valid;
   logic          push;
   logic          pop;
   logic [DW:0]   head;

   // Storage is write-only-when-free, so the head entry cannot change under a stall
   always_ff @(posedge clock) begin
      if (resetn && push) begin
         mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         pkt_q      <= '0;
         state_q    <= ST_HOLD;
         oversize_q <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         pkt_q      <= pkt_d;
         state_q    <= state_d;
         oversize_q <= oversize_d;
         run_q      <= run_d;
      end
   end

   always_comb begin
      full  = (fill_q == c_full_level);
      empty = (fill_q == '0);
      head  = mem_q[rd_ptr_q];

      if ((PKT_MODE != 0) && (state_q == ST_HOLD)) begin
         out_valid = (pkt_q != '0);
      end else begin
         out_valid = !empty;
      end

      s_tready = run_q & !full;
      push     = s_tvalid & s_tready;
      pop      = out_valid & m_tready;

      m_tvalid   = out_valid;
      m_tdata    = out_valid ? head[DW-1:0] : '0;
      m_tlast    = out_valid & head[DW];
      fill_level = fill_q;
      pkt_count  = pkt_q;
      oversize   = oversize_q;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      run_d      = 1'b1;
      fill_d     = fill_q;
      pkt_d      = pkt_q;
      state_d    = state_q;
      oversize_d = 1'b0;

      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase

      case ({push & s_tlast, pop & head[DW]})
         2'b10:   pkt_d = pkt_q + 1'b1;
         2'b01:   pkt_d = pkt_q - 1'b1;
         default: pkt_d = pkt_q;
      endcase

      // A full buffer with no complete packet can never release in HOLD
      case (state_q)
         ST_HOLD: begin
            if ((PKT_MODE != 0) && full && (pkt_q == '0)) begin
               state_d    = ST_FORCE;
               oversize_d = 1'b1;
            end
         end
         ST_FORCE: begin
            if (pop && head[DW]) begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_HOLD;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axis_stream_fifo : directed-vector bench for cut-through and packet modes
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_axis_stream_fifo;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   // dut a: cut-through, dut b: store-and-forward
   logic [7:0] a_s_tdata, a_m_tdata, b_s_tdata, b_m_tdata;
   logic a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast, a_oversize;
   logic b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast, b_oversize;
   logic [3:0] a_fill, a_pkt, b_fill, b_pkt;

   axis_stream_fifo #(.DW(8), .DEPTH(8), .PKT_MODE(0)) u_dut_a (
      .clock(clock), .resetn(resetn),
      .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tlast(a_s_tlast),
      .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tlast(a_m_tlast),
      .fill_level(a_fill), .pkt_count(a_pkt), .oversize(a_oversize)
   );

   axis_stream_fifo #(.DW(8), .DEPTH(8), .PKT_MODE(1)) u_dut_b (
      .clock(clock), .resetn(resetn),
      .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tlast(b_s_tlast),
      .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tlast(b_m_tlast),
      .fill_level(b_fill), .pkt_count(b_pkt), .oversize(b_oversize)
   );

   typedef struct {
      bit         dut;
      bit         sv;
      logic [7:0] sd;
      bit         sl;
      bit         mr;
      bit         e_sr;
      bit         e_mv;
      logic [7:0] e_md;
      bit         e_ml;
      logic [3:0] e_fill;
      logic [3:0] e_pkt;
   } vec_t;

   vec_t vt[$];
   int n_tests = 0;
   int n_fail  = 0;

   function automatic vec_t mk(bit dut, bit sv, logic [7:0] sd, bit sl, bit mr,
                               bit sr, bit mv, logic [7:0] md, bit ml, int fill, int pkt);
      vec_t v;
      v.dut = dut; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
      v.e_sr = sr; v.e_mv = mv; v.e_md = md; v.e_ml = ml;
      v.e_fill = 4'(fill); v.e_pkt = 4'(pkt);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // status word: {s_tready, m_tvalid, m_tdata, m_tlast, fill, pkt, oversize}
   function automatic logic [31:0] stat_a();
      return 32'({a_s_tready, a_m_tvalid, a_m_tdata, a_m_tlast, a_fill, a_pkt, a_oversize});
   endfunction
   function automatic logic [31:0] stat_b();
      return 32'({b_s_tready, b_m_tvalid, b_m_tdata, b_m_tlast, b_fill, b_pkt, b_oversize});
   endfunction
   function automatic logic [31:0] stat_exp(vec_t v);
      return 32'({v.e_sr, v.e_mv, v.e_md, v.e_ml, v.e_fill, v.e_pkt, 1'b0});
   endfunction

   task automatic idle_all();
      a_s_tvalid = 0; a_s_tdata = 0; a_s_tlast = 0; a_m_tready = 0;
      b_s_tvalid = 0; b_s_tdata = 0; b_s_tlast = 0; b_m_tready = 0;
   endtask

   initial begin
      logic [8:0] exp_q[$];
      logic [8:0] held, expw;
      bit   stall_prev;
      int   sent, rcvd, ov_cnt;

      // cut-through streaming at full rate
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(0, 1, 8'(i + 1), 0, 1, 1, i > 0, (i > 0) ? 8'(i) : 8'h00, 0, (i > 0) ? 1 : 0, 0));
      vt.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 8'h08, 0, 1, 0));
      vt.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 0));
      // fill to DEPTH under backpressure, tlast on 0x14 and 0x18
      for (int k = 0; k < 8; k++)
         vt.push_back(mk(0, 1, 8'(8'h11 + k), (k == 3) || (k == 7), 0, 1, k > 0,
                         (k > 0) ? 8'h11 : 8'h00, 0, k, (k >= 4) ? 1 : 0));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h11, 0, 8, 2));
      vt.push_back(mk(0, 1, 8'h99, 1, 1, 0, 1, 8'h11, 0, 8, 2));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h12, 0, 7, 2));
      for (int j = 0; j < 7; j++)
         vt.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 8'(8'h12 + j), (j == 2) || (j == 6), 7 - j, (j <= 2) ? 2 : 1));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0));
      // store-and-forward of a 3-beat packet
      vt.push_back(mk(1, 1, 8'h31, 0, 1, 1, 0, 8'h00, 0, 0, 0));
      vt.push_back(mk(1, 1, 8'h32, 0, 1, 1, 0, 8'h00, 0, 1, 0));
      vt.push_back(mk(1, 1, 8'h33, 1, 1, 1, 0, 8'h00, 0, 2, 0));
      vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 1, 8'h31, 0, 3, 1));
      vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 1, 8'h32, 0, 2, 1));
      vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 1, 8'h33, 1, 1, 1));
      vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 0));

      idle_all();
      resetn = 0;
      repeat (3) @(negedge clock);
      check("reset_a", stat_a(), 32'h0);
      check("reset_b", stat_b(), 32'h0);
      resetn = 1;
      @(negedge clock);

      foreach (vt[r]) begin
         @(negedge clock);
         idle_all();
         if (vt[r].dut == 0) begin
            a_s_tvalid = vt[r].sv; a_s_tdata = vt[r].sd; a_s_tlast = vt[r].sl; a_m_tready = vt[r].mr;
         end else begin
            b_s_tvalid = vt[r].sv; b_s_tdata = vt[r].sd; b_s_tlast = vt[r].sl; b_m_tready = vt[r].mr;
         end
         #1;
         check($sformatf("vec%0d", r), (vt[r].dut == 0) ? stat_a() : stat_b(), stat_exp(vt[r]));
      end

      // randomised handshakes against a queue model
      sent = 0; rcvd = 0; stall_prev = 0; held = '0;
      for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
         @(negedge clock);
         a_s_tvalid = (sent < 1000) && ($urandom_range(0, 1) == 1);
         a_s_tdata  = 8'($urandom);
         a_s_tlast  = 1'($urandom_range(0, 1));
         a_m_tready = 1'($urandom_range(0, 1));
         #1;
         if (stall_prev) check("stall_hold", {a_m_tvalid, a_m_tlast, a_m_tdata}, {1'b1, held});
         check("rand_fill", 32'(a_fill), 32'(exp_q.size()));
         if (a_m_tvalid && a_m_tready) begin
            expw = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
            check("rand_beat", {a_m_tlast, a_m_tdata}, expw);
            rcvd++;
         end
         if (a_s_tvalid && a_s_tready) begin
            exp_q.push_back({a_s_tlast, a_s_tdata});
            sent++;
         end
         stall_prev = a_m_tvalid && !a_m_tready;
         held = {a_m_tlast, a_m_tdata};
      end
      check("rand_count", 32'(rcvd), 32'd1000);

      // oversize packet in store-and-forward mode
      @(negedge clock);
      idle_all();
      sent = 0; rcvd = 0; ov_cnt = 0;
      for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
         @(negedge clock);
         b_s_tvalid = (sent < 10);
         b_s_tdata  = 8'(8'h20 + sent);
         b_s_tlast  = (sent == 9);
         b_m_tready = 1;
         #1;
         if (b_oversize) begin
            ov_cnt++;
            check("ovs_fill", 32'(b_fill), 32'd8);
         end
         if (b_m_tvalid) begin
            if (ov_cnt == 0) check("ovs_early_valid", 32'(b_m_tvalid), 32'd0);
            check("ovs_beat", {b_m_tlast, b_m_tdata}, {rcvd == 9, 8'(8'h20 + rcvd)});
            rcvd++;
         end
         if (b_s_tvalid && b_s_tready) sent++;
      end
      check("ovs_count", 32'(rcvd), 32'd10);
      check("ovs_pulses", 32'(ov_cnt), 32'd1);

      // back in HOLD: a partial packet is not released
      @(negedge clock);
      b_s_tvalid = 1; b_s_tdata = 8'h40; b_s_tlast = 0; b_m_tready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         b_s_tvalid = 0;
         #1;
         check("hold_partial", {b_m_tvalid, b_fill}, {1'b0, 4'd1});
      end
      @(negedge clock);
      b_s_tvalid = 1; b_s_tdata = 8'h41; b_s_tlast = 1;
      #1;
      check("hold_last_push", 32'(b_m_tvalid), 32'd0);
      @(negedge clock);
      b_s_tvalid = 0;
      #1;
      check("hold_out0", {b_m_tvalid, b_m_tlast, b_m_tdata}, {2'b10, 8'h40});
      @(negedge clock);
      #1;
      check("hold_out1", {b_m_tvalid, b_m_tlast, b_m_tdata}, {2'b11, 8'h41});
      @(negedge clock);
      #1;
      check("hold_empty", {b_m_tvalid, b_pkt, b_oversize}, 6'd0);
      idle_all();

      // reset in the middle of a packet
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         a_s_tvalid = 1; a_s_tdata = 8'(8'h50 + i); a_s_tlast = (i == 1); a_m_tready = 0;
      end
      @(negedge clock);
      a_s_tvalid = 0;
      #1;
      check("pre_reset", {a_fill, a_pkt}, {4'd5, 4'd1});
      resetn = 0;
      @(negedge clock);
      #1;
      check("mid_reset", stat_a(), 32'h0);
      resetn = 1;
      @(negedge clock);
      #1;
      check("post_reset_ready", {a_s_tready, a_m_tvalid, a_fill}, {2'b10, 4'd0});
      a_s_tvalid = 1; a_s_tdata = 8'h77; a_s_tlast = 0; a_m_tready = 1;
      @(negedge clock);
      a_s_tvalid = 0;
      #1;
      check("post_reset_first", {a_m_tvalid, a_m_tdata}, {1'b1, 8'h77});
      @(negedge clock);
      #1;
      check("post_reset_drain", {a_m_tvalid, a_fill}, {1'b0, 4'd0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
